// File: rtl/morph_pkg.sv
// Shared constants for the streaming 3x3 morphological operator.
package morph_pkg;

  localparam logic MODE_DILATE = 1'b0;
  localparam logic MODE_ERODE  = 1'b1;

  localparam logic SE_CROSS  = 1'b0;
  localparam logic SE_SQUARE = 1'b1;

  // Per-slot flag vector layout
  localparam int FLG_VALID = 0;
  localparam int FLG_FIRST = 1;
  localparam int FLG_LAST  = 2;
  localparam int FLG_TOP   = 3;
  localparam int FLG_BOT   = 4;
  localparam int FLG_MODE  = 5;
  localparam int FLG_SE    = 6;
  localparam int FLG_W     = 7;

  // Tap index = row*3 + column (row 0 = upper, column 0 = left); centre is tap 4
  localparam logic [8:0] MASK_CROSS  = 9'b010_111_010;
  localparam logic [8:0] MASK_SQUARE = 9'b111_111_111;

endpackage

// File: rtl/morph_minmax_chan.sv
// Combinational 9-tap min/max reducer for one channel; disabled taps are skipped.
module morph_minmax_chan
  import morph_pkg::*;
#(
  parameter int CH_WIDTH = 8
) (
  input  logic                  mode,
  input  logic [8:0]            mask,
  input  logic [9*CH_WIDTH-1:0] pix,
  output logic [CH_WIDTH-1:0]   res
);

  logic [CH_WIDTH-1:0] p;

  // The centre tap seeds the accumulator so an all-zero mask still yields the centre
  always_comb begin
    res = pix[4*CH_WIDTH +: CH_WIDTH];
    p   = '0;
    for (int i = 0; i < 9; i++) begin
      p = pix[i*CH_WIDTH +: CH_WIDTH];
      if (mask[i]) begin
        if (mode == MODE_DILATE) begin
          if (p > res) res = p;
        end else begin
          if (p < res) res = p;
        end
      end
    end
  end

endmodule

// File: rtl/morph3x3_stream.sv
// Streaming 3x3 dilate/erode over three pre-aligned rows with edge replication.
// Define MORPH_SQUARE_SE_EN to honour se_sel and build the diagonal taps.
module morph3x3_stream
  import morph_pkg::*;
#(
  parameter int PIC_WIDTH = 250,
  parameter int CH_WIDTH  = 8,
  parameter int CHANNELS  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [CH_WIDTH*CHANNELS-1:0] din1,
  input  logic [CH_WIDTH*CHANNELS-1:0] din2,
  input  logic [CH_WIDTH*CHANNELS-1:0] din3,
  input  logic                         row_top,
  input  logic                         row_bot,
  input  logic                         mode,
  input  logic                         se_sel,
  output logic                         valid_out,
  output logic [CH_WIDTH*CHANNELS-1:0] dout,
  output logic                         eol_out
);

  localparam int DW = CH_WIDTH * CHANNELS;
  localparam int CW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);

  logic [CW-1:0]    col;
  logic             tail_pending;
  logic             line_mode;
  logic [DW-1:0]    up_q[3], mid_q[3], dn_q[3];
  logic [FLG_W-1:0] flg_q[3];
  logic [DW-1:0]    up_n[3], mid_n[3], dn_n[3];
  logic [FLG_W-1:0] flg_n[3];
  logic [FLG_W-1:0] new_flg, cf;
  logic             shift, col_first, col_last, emit;
  logic [DW-1:0]    cu[3], cm[3], cd[3], tap[9];
  logic [8:0]       mask;
  logic [DW-1:0]    red;

`ifdef MORPH_SQUARE_SE_EN
  logic line_se;
`else
  logic unused_se;
  assign unused_se = se_sel;
`endif

  // Post-shift window; a shift without valid_in pushes a bubble into W0
  always_comb begin
    shift     = valid_in | tail_pending;
    col_first = valid_in && (col == '0);
    col_last  = valid_in && (col == COL_LAST);
    new_flg   = '0;
    new_flg[FLG_VALID] = valid_in;
    new_flg[FLG_FIRST] = col_first;
    new_flg[FLG_LAST]  = col_last;
    new_flg[FLG_TOP]   = valid_in & row_top;
    new_flg[FLG_BOT]   = valid_in & row_bot;
    new_flg[FLG_MODE]  = valid_in & (col_first ? mode : line_mode);
`ifdef MORPH_SQUARE_SE_EN
    new_flg[FLG_SE]    = valid_in & (col_first ? se_sel : line_se);
`endif
    for (int i = 0; i < 3; i++) begin
      up_n[i]  = up_q[i];
      mid_n[i] = mid_q[i];
      dn_n[i]  = dn_q[i];
      flg_n[i] = flg_q[i];
    end
    if (shift) begin
      up_n[0]  = din1;
      mid_n[0] = din2;
      dn_n[0]  = din3;
      flg_n[0] = new_flg;
      for (int i = 1; i < 3; i++) begin
        up_n[i]  = up_q[i-1];
        mid_n[i] = mid_q[i-1];
        dn_n[i]  = dn_q[i-1];
        flg_n[i] = flg_q[i-1];
      end
    end
    emit = shift && flg_n[1][FLG_VALID] &&
           ((flg_n[0][FLG_VALID] && !flg_n[0][FLG_FIRST]) || flg_n[1][FLG_LAST]);
  end

  // Replicate the centre column/row across line and frame edges
  always_comb begin
    cf    = flg_n[1];
    cu[1] = up_n[1];
    cm[1] = mid_n[1];
    cd[1] = dn_n[1];
    cu[0] = cf[FLG_FIRST] ? up_n[1]  : up_n[2];
    cm[0] = cf[FLG_FIRST] ? mid_n[1] : mid_n[2];
    cd[0] = cf[FLG_FIRST] ? dn_n[1]  : dn_n[2];
    cu[2] = cf[FLG_LAST]  ? up_n[1]  : up_n[0];
    cm[2] = cf[FLG_LAST]  ? mid_n[1] : mid_n[0];
    cd[2] = cf[FLG_LAST]  ? dn_n[1]  : dn_n[0];
    for (int k = 0; k < 3; k++) begin
      tap[k]     = cf[FLG_TOP] ? cm[k] : cu[k];
      tap[3 + k] = cm[k];
      tap[6 + k] = cf[FLG_BOT] ? cm[k] : cd[k];
    end
`ifdef MORPH_SQUARE_SE_EN
    mask = (cf[FLG_SE] == SE_SQUARE) ? MASK_SQUARE : MASK_CROSS;
`else
    tap[0] = '0;
    tap[2] = '0;
    tap[6] = '0;
    tap[8] = '0;
    mask   = MASK_CROSS;
`endif
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic [9*CH_WIDTH-1:0] pix;

    always_comb begin
      pix = '0;
      for (int t = 0; t < 9; t++) pix[t*CH_WIDTH +: CH_WIDTH] = tap[t][ch*CH_WIDTH +: CH_WIDTH];
    end

    morph_minmax_chan #(.CH_WIDTH(CH_WIDTH)) u_red (
      .mode (cf[FLG_MODE]),
      .mask (mask),
      .pix  (pix),
      .res  (red[ch*CH_WIDTH +: CH_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      tail_pending <= 1'b0;
      line_mode    <= MODE_DILATE;
`ifdef MORPH_SQUARE_SE_EN
      line_se      <= SE_CROSS;
`endif
      valid_out    <= 1'b0;
      dout         <= '0;
      eol_out      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        up_q[i]  <= '0;
        mid_q[i] <= '0;
        dn_q[i]  <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        up_q[i]  <= up_n[i];
        mid_q[i] <= mid_n[i];
        dn_q[i]  <= dn_n[i];
        flg_q[i] <= flg_n[i];
      end
      if (valid_in) col <= col_last ? '0 : col + 1'b1;
      if (col_last) tail_pending <= 1'b1;
      else if (shift) tail_pending <= 1'b0;
      if (col_first) line_mode <= mode;
`ifdef MORPH_SQUARE_SE_EN
      if (col_first) line_se <= se_sel;
`endif
      valid_out <= emit;
      eol_out   <= emit && cf[FLG_LAST];
      if (emit) dout <= red;
    end
  end

endmodule

// File: tb/tb_morph3x3_stream.sv
// Self-checking bench for morph3x3_stream against a neighbourhood-based reference model.
`timescale 1ns/1ps
module tb_morph3x3_stream;

  localparam int PIC_WIDTH = 4;
  localparam int CH_WIDTH  = 8;
  localparam int CHANNELS  = 3;
  localparam int DW        = CH_WIDTH * CHANNELS;
`ifdef MORPH_SQUARE_SE_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, valid_in, row_top, row_bot, mode, se_sel;
  logic [DW-1:0] din1, din2, din3, dout;
  logic          valid_out, eol_out;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] line_up[PIC_WIDTH], line_mid[PIC_WIDTH], line_dn[PIC_WIDTH];
  logic [DW-1:0] exp_q[$], got_q[$];
  logic          exp_eol_q[$], got_eol_q[$];

  logic [DW-1:0] bb_up[3][PIC_WIDTH], bb_mid[3][PIC_WIDTH], bb_dn[3][PIC_WIDTH];
  logic          bb_md[3], bb_se[3], bb_top[3], bb_bot[3];

  always #5 clk = ~clk;

  morph3x3_stream #(.PIC_WIDTH(PIC_WIDTH), .CH_WIDTH(CH_WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .din1      (din1),
    .din2      (din2),
    .din3      (din3),
    .row_top   (row_top),
    .row_bot   (row_bot),
    .mode      (mode),
    .se_sel    (se_sel),
    .valid_out (valid_out),
    .dout      (dout),
    .eol_out   (eol_out)
  );

  function automatic logic [DW-1:0] rep(input logic [CH_WIDTH-1:0] v);
    return {CHANNELS{v}};
  endfunction

  function automatic logic [DW-1:0] rnd_pix();
    return DW'($urandom);
  endfunction

  // Reference: per channel, max/min over the clamped 3x3 neighbourhood of the line
  function automatic logic [DW-1:0] model_pixel(input int c, input logic md, input logic se,
                                                input logic top, input logic bot);
    logic [DW-1:0]       res;
    logic [CH_WIDTH-1:0] acc, v;
    int                  cc;
    bit                  sq;
    sq  = SQ_EN && se;
    res = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      acc = line_mid[c][ch*CH_WIDTH +: CH_WIDTH];
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (!sq && dr != 0 && dc != 0) continue;
          cc = c + dc;
          if (cc < 0) cc = 0;
          if (cc > PIC_WIDTH - 1) cc = PIC_WIDTH - 1;
          if (dr == -1 && !top)    v = line_up[cc][ch*CH_WIDTH +: CH_WIDTH];
          else if (dr == 1 && !bot) v = line_dn[cc][ch*CH_WIDTH +: CH_WIDTH];
          else                      v = line_mid[cc][ch*CH_WIDTH +: CH_WIDTH];
          if (md) acc = (v < acc) ? v : acc;
          else    acc = (v > acc) ? v : acc;
        end
      end
      res[ch*CH_WIDTH +: CH_WIDTH] = acc;
    end
    return res;
  endfunction

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Every output pulse is matched in order against the model queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out) begin
        got_q.push_back(dout);
        got_eol_q.push_back(eol_out);
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_pulse: observed dout %h expected no pulse", dout);
        end
        if (exp_q.size() > 0) begin
          check_output("dout", dout, exp_q.pop_front());
          check_output("eol_out", DW'(eol_out), DW'(exp_eol_q.pop_front()));
        end
      end else begin
        check_output("eol_idle", DW'(eol_out), '0);
      end
    end
  end

  task automatic fill_random();
    for (int c = 0; c < PIC_WIDTH; c++) begin
      line_up[c]  = rnd_pix();
      line_mid[c] = rnd_pix();
      line_dn[c]  = rnd_pix();
    end
  endtask

  task automatic fill_const(input logic [DW-1:0] u, input logic [DW-1:0] m, input logic [DW-1:0] d);
    for (int c = 0; c < PIC_WIDTH; c++) begin
      line_up[c]  = u;
      line_mid[c] = m;
      line_dn[c]  = d;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    valid_in = 1'b0;
    din1 = rnd_pix(); din2 = rnd_pix(); din3 = rnd_pix();
    repeat (n - 1) @(posedge clk);
  endtask

  // Drives ncols columns of the current line; a partial line expects all but its last pixel
  task automatic apply_stimulus(input int ncols, input logic md, input logic se, input logic top,
                                input logic bot, input int gap, input bit holes);
    for (int c = 0; c < PIC_WIDTH; c++) begin
      if (ncols == PIC_WIDTH || c < ncols - 1) begin
        exp_q.push_back(model_pixel(c, md, se, top, bot));
        exp_eol_q.push_back(c == PIC_WIDTH - 1);
      end
    end
    for (int c = 0; c < ncols; c++) begin
      if (holes && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        valid_in = 1'b0;
        din1 = rnd_pix(); din2 = rnd_pix(); din3 = rnd_pix();
        mode = 1'($urandom); se_sel = 1'($urandom);
      end
      @(posedge clk); #1;
      valid_in = 1'b1;
      din1     = line_up[c];
      din2     = line_mid[c];
      din3     = line_dn[c];
      row_top  = top;
      row_bot  = bot;
      mode     = (c == 0) ? md : 1'($urandom);
      se_sel   = (c == 0) ? se : 1'($urandom);
    end
    if (gap > 0) idle(gap);
  endtask

  task automatic check_line(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    logic [DW-1:0] ev[4];
    ev = '{e0, e1, e2, e3};
    check_output({tag, "_count"}, DW'(got_q.size()), DW'(4));
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_output($sformatf("%s_px%0d", tag, i), got_q[i], ev[i]);
        check_output($sformatf("%s_eol%0d", tag, i), DW'(got_eol_q[i]), DW'(i == 3));
      end
    end
    check_output({tag, "_drained"}, DW'(exp_q.size()), '0);
    got_q.delete();
    got_eol_q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b1; row_top = 1'b0; row_bot = 1'b0; mode = 1'b0; se_sel = 1'b0;
    din1 = rnd_pix(); din2 = rnd_pix(); din3 = rnd_pix();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid_out", DW'(valid_out), '0);
    check_output("reset_dout", dout, '0);
    check_output("reset_eol_out", DW'(eol_out), '0);
    rst = 1'b0; valid_in = 1'b0;
    mon_en = 1'b1;

    $display("[TB] dilate cross");
    fill_const(rep(10), rep(10), rep(10));
    line_mid[1] = rep(200);
    apply_stimulus(PIC_WIDTH, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    check_line("dilate", rep(200), rep(200), rep(200), rep(10));

    $display("[TB] erode cross");
    fill_const(rep(50), rep(50), rep(50));
    line_mid[1] = rep(5);
    apply_stimulus(PIC_WIDTH, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    check_line("erode", rep(5), rep(5), rep(5), rep(50));

    $display("[TB] row edges");
    fill_const(rep(255), rep(0), rep(0));
    apply_stimulus(PIC_WIDTH, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(4);
    check_line("row_top", rep(0), rep(0), rep(0), rep(0));
    apply_stimulus(PIC_WIDTH, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    check_line("row_mid", rep(255), rep(255), rep(255), rep(255));

    $display("[TB] structuring element");
    fill_const(rep(0), rep(0), rep(0));
    line_up[0] = rep(99);
    apply_stimulus(PIC_WIDTH, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
`ifdef MORPH_SQUARE_SE_EN
    check_line("square", rep(99), rep(99), rep(0), rep(0));
`else
    check_line("square_off", rep(99), rep(0), rep(0), rep(0));
`endif
    apply_stimulus(PIC_WIDTH, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    check_line("cross", rep(99), rep(0), rep(0), rep(0));

    $display("[TB] per-channel max");
    fill_const(24'h201030, 24'h201030, 24'h201030);
    line_mid[1] = 24'h10FF20;
    apply_stimulus(PIC_WIDTH, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    check_line("per_chan", 24'h20FF30, 24'h20FF30, 24'h20FF30, 24'h201030);

    $display("[TB] back-to-back and gapped lines");
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < PIC_WIDTH; c++) begin
        bb_up[l][c] = rnd_pix(); bb_mid[l][c] = rnd_pix(); bb_dn[l][c] = rnd_pix();
      end
      bb_md[l] = 1'($urandom); bb_se[l] = 1'($urandom);
      bb_top[l] = (l == 0); bb_bot[l] = (l == 2);
    end
    for (int run = 0; run < 2; run++) begin
      for (int l = 0; l < 3; l++) begin
        for (int c = 0; c < PIC_WIDTH; c++) begin
          line_up[c] = bb_up[l][c]; line_mid[c] = bb_mid[l][c]; line_dn[c] = bb_dn[l][c];
        end
        apply_stimulus(PIC_WIDTH, bb_md[l], bb_se[l], bb_top[l], bb_bot[l], (run == 0) ? 0 : 2, 1'b0);
      end
      idle(4);
      check_output($sformatf("lines_count_run%0d", run), DW'(got_q.size()), DW'(12));
      check_output($sformatf("lines_drained_run%0d", run), DW'(exp_q.size()), '0);
      got_q.delete();
      got_eol_q.delete();
    end

    $display("[TB] reset mid-line");
    fill_random();
    apply_stimulus(3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; valid_in = 1'b1; din1 = rnd_pix(); din2 = rnd_pix(); din3 = rnd_pix();
    repeat (3) @(posedge clk);
    #1;
    check_output("midreset_valid_out", DW'(valid_out), '0);
    check_output("midreset_dout", dout, '0);
    rst = 1'b0; valid_in = 1'b0;
    repeat (3) @(posedge clk);
    check_output("midreset_partial_count", DW'(got_q.size()), DW'(2));
    got_q.delete();
    got_eol_q.delete();
    fill_random();
    apply_stimulus(PIC_WIDTH, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    check_output("postreset_count", DW'(got_q.size()), DW'(4));
    check_output("postreset_drained", DW'(exp_q.size()), '0);
    got_q.delete();
    got_eol_q.delete();

    $display("[TB] random lines");
    for (int l = 0; l < 30; l++) begin
      fill_random();
      apply_stimulus(PIC_WIDTH, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 2), 1'b1);
    end
    idle(6);
    check_output("random_count", DW'(got_q.size()), DW'(30 * PIC_WIDTH));
    check_output("random_drained", DW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
